uart_rx_fifo: RTL and testbench

//  Receive FIFO downstream of the UART RX deserialiser. Each push stores a

---
 rtl/uart_rx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: stores {bi,fe,pe,din} per push and presents the head show-ahead; written data is visible the cycle after push.
// No backpressure: a push into a full FIFO is dropped (overwrites in holding-register mode) and raises sticky overrun.
module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int DW    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DW-1:0]            din,
   input  logic                     pe_in,
   input  logic                     fe_in,
   input  logic                     bi_in,
   input  logic                     pop,
   input  logic                     fifo_en,
   input  logic                     fifo_clr,
   input  logic                     ovr_clr,
   input  logic [1:0]               trig_lvl,
   output logic [DW-1:0]            dout,
   output logic                     dout_pe,
   output logic                     dout_fe,
   output logic                     dout_bi,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     data_ready,
   output logic                     overrun,
   output logic                     trig_hit,
   output logic                     err_in_fifo
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DW + 3;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] cnt, errcnt;
   logic          ovr_q;
   logic          fifo_en_q;

   logic [EW-1:0] entry, head;
   logic          is_empty, is_full, flush, do_pop, do_push, ovwr, ovr_set;
   logic          in_err, head_err;
   logic [CW-1:0] cnt_nxt, errcnt_nxt;
   int            trig_n;

   always_comb begin
      entry    = {bi_in, fe_in, pe_in, din};
      head     = mem[rd_ptr];
      in_err   = pe_in | fe_in | bi_in;
      head_err = |head[EW-1:DW];
      is_empty = (cnt == '0);
      is_full  = fifo_en ? (cnt == CW'(DEPTH)) : !is_empty;
      // A mode change invalidates the stored layout, so it flushes like fifo_clr.
      flush    = fifo_clr | (fifo_en != fifo_en_q);
      do_pop   = pop & !is_empty;
      do_push  = push & (!is_full | do_pop);
      ovr_set  = push & is_full & !pop & !flush;
      ovwr     = ovr_set & !fifo_en;
      cnt_nxt  = cnt + CW'(do_push) - CW'(do_pop);
      if (ovwr)
         errcnt_nxt = CW'(in_err);
      else
         errcnt_nxt = errcnt + CW'(do_push & in_err) - CW'(do_pop & head_err);
   end

   always_ff @(posedge clk) begin
      if (!flush && (do_push || ovwr))
         mem[ovwr ? rd_ptr : wr_ptr] <= entry;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         cnt       <= '0;
         errcnt    <= '0;
         ovr_q     <= 1'b0;
         fifo_en_q <= 1'b0;
      end else begin
         fifo_en_q <= fifo_en;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            errcnt <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt    <= cnt_nxt;
            errcnt <= errcnt_nxt;
         end
         // Set wins over a coincident clear; flush leaves overrun alone.
         if (ovr_set)
            ovr_q <= 1'b1;
         else if (ovr_clr)
            ovr_q <= 1'b0;
      end
   end

   always_comb begin
      case (trig_lvl)
         2'b00:   trig_n = 1;
         2'b01:   trig_n = 4;
         2'b10:   trig_n = 8;
         default: trig_n = 14;
      endcase
   end

   assign dout        = is_empty ? '0   : head[DW-1:0];
   assign dout_pe     = is_empty ? 1'b0 : head[DW];
   assign dout_fe     = is_empty ? 1'b0 : head[DW+1];
   assign dout_bi     = is_empty ? 1'b0 : head[DW+2];
   assign count       = cnt;
   assign empty       = is_empty;
   assign full        = is_full;
   assign data_ready  = !is_empty;
   assign overrun     = ovr_q;
   assign trig_hit    = fifo_en ? (int'(cnt) >= trig_n) : !is_empty;
   assign err_in_fifo = (errcnt != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized checks of uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       push = 1'b0, pe_in = 1'b0, fe_in = 1'b0, bi_in = 1'b0, pop = 1'b0;
   logic       fifo_en = 1'b1, fifo_clr = 1'b0, ovr_clr = 1'b0;
   logic [1:0] trig_lvl = 2'b00;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       dout_pe, dout_fe, dout_bi, empty, full, data_ready, overrun, trig_hit, err_in_fifo;
   logic [4:0] count;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [10:0] q[$];
   logic        m_ovr = 1'b0;
   logic        m_fen_prev = 1'b0;

   uart_rx_fifo #(.DEPTH(16), .DW(8)) dut (
      .clk(clk), .rst(rst), .push(push), .din(din), .pe_in(pe_in), .fe_in(fe_in),
      .bi_in(bi_in), .pop(pop), .fifo_en(fifo_en), .fifo_clr(fifo_clr), .ovr_clr(ovr_clr),
      .trig_lvl(trig_lvl), .dout(dout), .dout_pe(dout_pe), .dout_fe(dout_fe), .dout_bi(dout_bi),
      .count(count), .empty(empty), .full(full), .data_ready(data_ready), .overrun(overrun),
      .trig_hit(trig_hit), .err_in_fifo(err_in_fifo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_trig(input logic [1:0] t);
      case (t)
         2'b00:   return 1;
         2'b01:   return 4;
         2'b10:   return 8;
         default: return 14;
      endcase
   endfunction

   task automatic check_all(input string ph);
      int         n = q.size();
      int         cap = fifo_en ? 16 : 1;
      int         nerr = 0;
      logic [10:0] h = (n > 0) ? q[0] : 11'h0;
      foreach (q[i]) if (q[i][10:8] != 3'b000) nerr++;
      chk({ph, "_count"}, 32'(count), 32'(n));
      chk({ph, "_empty"}, 32'(empty), 32'(n == 0));
      chk({ph, "_full"}, 32'(full), 32'(n == cap));
      chk({ph, "_ready"}, 32'(data_ready), 32'(n != 0));
      chk({ph, "_ovr"}, 32'(overrun), 32'(m_ovr));
      chk({ph, "_trig"}, 32'(trig_hit), 32'(fifo_en ? (n >= m_trig(trig_lvl)) : (n != 0)));
      chk({ph, "_err"}, 32'(err_in_fifo), 32'(nerr != 0));
      chk({ph, "_dout"}, 32'(dout), 32'(h[7:0]));
      chk({ph, "_stat"}, 32'({dout_bi, dout_fe, dout_pe}), 32'(h[10:8]));
   endtask

   // One clock: drive strobes, apply the spec rules to the model at the edge, check at negedge.
   task automatic step(input logic ps, input logic [7:0] d, input logic [2:0] st,
                       input logic pp, input logic clr, input logic oc, input string ph);
      logic flush, fl, set;
      int   cap;
      push = ps; din = d; {bi_in, fe_in, pe_in} = st; pop = pp; fifo_clr = clr; ovr_clr = oc;
      @(posedge clk);
      flush = clr || (fifo_en != m_fen_prev);
      cap = fifo_en ? 16 : 1;
      fl = (q.size() == cap);
      set = 1'b0;
      if (flush) q.delete();
      else if (ps && fl && !pp) begin
         set = 1'b1;
         if (!fifo_en) q[0] = {st, d};
      end else begin
         if (pp && q.size() > 0) void'(q.pop_front());
         if (ps) q.push_back({st, d});
      end
      if (set) m_ovr = 1'b1;
      else if (oc) m_ovr = 1'b0;
      m_fen_prev = fifo_en;
      #1;
      push = 1'b0; pop = 1'b0; fifo_clr = 1'b0; ovr_clr = 1'b0; {bi_in, fe_in, pe_in} = 3'b000;
      @(negedge clk);
      check_all(ph);
   endtask

   task automatic do_push(input logic [7:0] d, input logic [2:0] st, input string ph);
      step(1'b1, d, st, 1'b0, 1'b0, 1'b0, ph);
   endtask

   task automatic do_pop(input string ph);
      step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, ph);
   endtask

   task automatic idle(input string ph);
      step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, ph);
   endtask

   task automatic model_reset();
      q.delete();
      m_ovr = 1'b0;
      m_fen_prev = 1'b0;
   endtask

   initial begin
      // Reset
      model_reset();
      repeat (3) @(negedge clk);
      check_all("rst");
      chk("rst_empty_const", 32'(empty), 32'd1);
      rst = 1'b1;
      idle("idle0");

      // 1: basic push/pop
      do_push(8'h45, 3'b000, "t1_push");
      chk("t1_dout_const", 32'(dout), 32'h45);
      chk("t1_count_const", 32'(count), 32'd1);
      do_pop("t1_pop");
      chk("t1_empty_const", 32'(empty), 32'd1);

      // 2: trigger level 4
      trig_lvl = 2'b01;
      for (int i = 0; i < 3; i++) do_push(8'($urandom), 3'b000, "t2_push");
      chk("t2_trig_lo", 32'(trig_hit), 32'd0);
      do_push(8'($urandom), 3'b000, "t2_push4");
      chk("t2_trig_hi", 32'(trig_hit), 32'd1);
      do_pop("t2_pop");
      chk("t2_trig_drop", 32'(trig_hit), 32'd0);

      // 3: fill, overrun, drain in order
      trig_lvl = 2'b11;
      step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, "t3_clr");
      for (int i = 0; i < 16; i++) do_push(8'(i), 3'b000, "t3_fill");
      do_push(8'hAA, 3'b000, "t3_ovf");
      chk("t3_full_const", 32'(full), 32'd1);
      chk("t3_ovr_const", 32'(overrun), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk("t3_order", 32'(dout), 32'(i));
         do_pop("t3_drain");
      end
      step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1, "t3_ovrclr");
      chk("t3_ovr_cleared", 32'(overrun), 32'd0);

      // 4: push+pop while full, pop while empty, push+pop while empty
      for (int i = 0; i < 16; i++) do_push(8'($urandom), 3'($urandom), "t4_fill");
      step(1'b1, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0, "t4_pp_full");
      chk("t4_count16", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) do_pop("t4_drain");
      do_pop("t4_pop_empty");
      step(1'b1, 8'h66, 3'b000, 1'b1, 1'b0, 1'b0, "t4_pp_empty");
      chk("t4_count1", 32'(count), 32'd1);
      do_pop("t4_last");

      // 5: error-in-fifo tracking
      do_push(8'h11, 3'b010, "t5_err");
      do_push(8'h22, 3'b000, "t5_clean");
      chk("t5_dout_fe", 32'(dout_fe), 32'd1);
      do_pop("t5_pop");
      chk("t5_err_gone", 32'(err_in_fifo), 32'd0);
      chk("t5_dout", 32'(dout), 32'h22);
      do_pop("t5_pop2");

      // 6: holding-register mode, mode toggle, clear with push, mid-burst reset
      fifo_en = 1'b0;
      idle("t6_mode0");
      do_push(8'h33, 3'b000, "t6_p33");
      do_push(8'h44, 3'b001, "t6_p44");
      chk("t6_dout44", 32'(dout), 32'h44);
      fifo_en = 1'b1;
      idle("t6_toggle");
      do_push(8'h77, 3'b100, "t6_p77");
      step(1'b1, 8'h88, 3'b000, 1'b0, 1'b1, 1'b0, "t6_clr_push");
      chk("t6_ovr_kept", 32'(overrun), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(99) < 2) fifo_en = ~fifo_en;
         if ($urandom_range(99) < 5) trig_lvl = 2'($urandom);
         step(1'($urandom_range(99) < 60), 8'($urandom),
              ($urandom_range(3) == 0) ? 3'($urandom) : 3'b000,
              1'($urandom_range(99) < 45), 1'($urandom_range(99) < 3),
              1'($urandom_range(99) < 10), "rnd");
      end

      // Reset asserted in the middle of a burst
      fifo_en = 1'b1;
      idle("mid_pre");
      for (int i = 0; i < 5; i++) do_push(8'($urandom), 3'b001, "mid_push");
      m_ovr = m_ovr;
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all("mid_rst");
      chk("mid_rst_count", 32'(count), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle("post_rst");
      do_push(8'h5A, 3'b000, "post_push");
      chk("post_dout", 32'(dout), 32'h5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
